uart_rx_with_buf: RTL and testbench
===================================

# uart_rx_with_buf

Buffered 8N1 UART receiver, the receive-side counterpart of `uart_tx_with_buf`. It samples the asynchronous serial line `rxd` at bit centres and assembles bytes LSB-first. Each valid byte goes into a show-ahead FIFO, which the processor core drains at its own pace. Framing errors and overruns are reported as single-cycle pulses.

## Interface
- `CLK_PER_HALF_BIT`, default 434: clock cycles per half bit period (100 MHz / 115200 baud); minimum 2.
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 entries.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `rxd`  in  1  serial line; idles high; asynchronous to `clk`.
- `rd_en`  in  1  pop the head byte; ignored while `rdata_valid`=0.
- `rdata`  out  8  head byte of the FIFO (show-ahead); 8'h00 while empty.
- `rdata_valid`  out  1  FIFO is non-empty.
- `count`  out  DEPTH_LOG2+1  number of bytes currently stored.
- `ferr`  out  1  one-cycle pulse: stop bit sampled low, byte discarded.
- `overrun`  out  1  one-cycle pulse: valid byte arrived while FIFO full and no pop in that cycle; byte discarded.

## Operation
- `rxd` passes through a 2-flop synchronizer, both flops reset to 1. All decisions below use the synchronized value `rxs`.
- The FSM has five states, using a bit-timer `tcnt` and a bit index `bidx` (0..7).
  - IDLE: when `rxs`=0, go to START and clear `tcnt`.
  - START: at `tcnt`=CLK_PER_HALF_BIT-1, sample `rxs`.
    - If 0: go to DATA, clear `tcnt` and `bidx`.
    - If 1: treat as a glitch and return to IDLE with no error.
  - DATA: at `tcnt`=2*CLK_PER_HALF_BIT-1, shift `rxs` into bit `bidx` of the shift register and clear `tcnt`.
    - After `bidx`=7 has been sampled, go to STOP.
  - STOP: at `tcnt`=2*CLK_PER_HALF_BIT-1, sample `rxs`.
    - If 1: write the byte to the FIFO, or pulse `overrun` if the FIFO is full and there is no pop this cycle. Go to IDLE.
    - If 0: pulse `ferr` and go to BREAK.
  - BREAK: wait for `rxs`=1, then go to IDLE. A held-low line therefore does not produce repeated `ferr` pulses.
- FIFO behaviour:
  - Write and pop in the same cycle are both performed; `count` is unchanged.
  - When full, a write with a simultaneous pop is accepted.
  - Pointers wrap modulo 2^DEPTH_LOG2.
  - `count` saturates naturally at 2^DEPTH_LOG2, because a write is never performed when full without a pop.
- `rd_en` while empty has no effect and does not underflow.

## Timing
- Reset values:
  - FSM state IDLE, `tcnt`=0, `bidx`=0, shift register 0, FIFO pointers 0.
  - Outputs: `rdata`=8'h00, `rdata_valid`=0, `count`=0, `ferr`=0, `overrun`=0.
- Reset asserted mid-frame abandons the frame. After release the receiver starts in IDLE, so bits still arriving on `rxd` may be misread as a new start bit. Upstream tolerates this.
- Synchronizer delay is 2 cycles from a `rxd` edge to `rxs`.
- Let H = CLK_PER_HALF_BIT and T0 = the cycle IDLE sees `rxs`=0.
  - Start-bit sample at T0+H.
  - Data bit k sample at T0+H+2H*(k+1).
  - Stop-bit sample at T0+19H.
- `rdata_valid` and `count` update in the cycle after the stop-bit sample.
- `ferr` and `overrun` are asserted in the cycle after the stop-bit sample, for exactly one cycle.
- Pop: the cycle after `rd_en`=1 with the FIFO non-empty, `rdata` shows the next entry and `count` decrements.
- Back-to-back frames are supported. IDLE is re-entered at T0+19H, so a next start edge arriving at T0+20H is caught.
- Baud tolerance is about ±4% cumulative over 10 bits.

## Structure
- Package `uart_pkg` holds:
  - the FSM state enum (IDLE, START, DATA, STOP, BREAK);
  - the default constants `CLK_PER_HALF_BIT_DEFAULT`=434 and `DEPTH_LOG2_DEFAULT`=4, shared with the transmitter.
- Sub-module `uart_fifo` (parameter DEPTH_LOG2, 8-bit, show-ahead, with `count`) is factored out so that `uart_tx_with_buf` can reuse it.
- The synchronizer, FSM and shift register stay in the top module.

## Test plan
All scenarios use H=4 (80 cycles per frame) and DEPTH_LOG2=2.
1. Single frame 0xA5 on `rxd` → `rdata_valid` rises 1 cycle after the stop sample; `rdata`=8'hA5, `count`=1; `rd_en` pulse → `rdata_valid`=0, `rdata`=8'h00.
2. 5 back-to-back frames 0x01..0x05 with no pops → `count`=4, one `overrun` pulse on frame 5; pops return 0x01..0x04 in order.
3. FIFO full, frame 0x77 with `rd_en`=1 in the write cycle → no `overrun`; `count` stays 4; the last pop returns 0x77.
4. Frame with stop bit 0 (0x3C), then line held low for 200 cycles, then high, then frame 0x5A → one `ferr` pulse only; the FIFO contains only 0x5A.
5. 1-cycle low glitch on `rxd` while idle → no byte, no `ferr`; FSM back in IDLE by T0+H+1.
6. `rstn` low for 3 cycles mid-frame (after bit 3), then line idle → all outputs at reset values, no byte written; a following 0xC3 frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and default constants
package uart_pkg;

  localparam int CLK_PER_HALF_BIT_DEFAULT = 434;
  localparam int DEPTH_LOG2_DEFAULT       = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - 8-bit show-ahead byte FIFO with occupancy count
module uart_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_en,
  input  logic [7:0]            wdata,
  input  logic                  rd_en,
  output logic [7:0]            rdata,
  output logic                  rdata_valid,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  empty;
  logic                  do_wr;
  logic                  do_rd;

  assign empty       = (count == '0);
  assign full        = (count == (DEPTH_LOG2 + 1)'(DEPTH));
  assign rdata_valid = !empty;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a write alongside it
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  // Head byte is presented combinationally; zero when nothing is stored
  assign rdata = empty ? 8'h00 : mem[rd_ptr];

  // Storage array; contents are only meaningful between the pointers, so no reset
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks net writes minus pops
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + (DEPTH_LOG2 + 1)'(1);
        2'b01:   count <= count - (DEPTH_LOG2 + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_with_buf.sv
// rtl/uart_rx_with_buf.sv - buffered 8N1 UART receiver with framing and overrun pulses
module uart_rx_with_buf
  import uart_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = CLK_PER_HALF_BIT_DEFAULT,
  parameter int DEPTH_LOG2       = DEPTH_LOG2_DEFAULT
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                rxd,
  input  logic                rd_en,
  output logic [7:0]          rdata,
  output logic                rdata_valid,
  output logic [DEPTH_LOG2:0] count,
  output logic                ferr,
  output logic                overrun
);

  // Bit timer must reach one full bit period minus one
  localparam int TW = $clog2(2 * CLK_PER_HALF_BIT);
  localparam logic [TW-1:0] T_HALF = TW'(CLK_PER_HALF_BIT - 1);
  localparam logic [TW-1:0] T_FULL = TW'(2 * CLK_PER_HALF_BIT - 1);

  logic          rx_meta;
  logic          rxs;
  rx_state_e     state;
  logic [TW-1:0] tcnt;
  logic [2:0]    bidx;
  logic [7:0]    shreg;
  logic          stop_hit;
  logic          fifo_wr;
  logic          fifo_full;

  // Two-flop synchronizer; resets to the idle (high) line level so reset never fakes a start bit
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  // Stop-bit sample point; a high stop bit hands the assembled byte to the FIFO
  always_comb begin
    stop_hit = (state == STOP) && (tcnt == T_FULL);
    fifo_wr  = stop_hit && rxs;
  end

  // Receive FSM: centre-samples start, data and stop bits and raises one-cycle status pulses
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      tcnt    <= '0;
      bidx    <= '0;
      shreg   <= '0;
      ferr    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      ferr    <= 1'b0;
      overrun <= 1'b0;
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (!rxs) begin
            state <= START;
          end
        end
        START: begin
          if (tcnt == T_HALF) begin
            tcnt <= '0;
            if (!rxs) begin
              state <= DATA;
              bidx  <= '0;
            end else begin
              // Line went back high before mid start bit: a glitch, not a frame
              state <= IDLE;
            end
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        DATA: begin
          if (tcnt == T_FULL) begin
            tcnt        <= '0;
            shreg[bidx] <= rxs;
            if (bidx == 3'd7) begin
              state <= STOP;
            end else begin
              bidx <= bidx + 3'd1;
            end
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        STOP: begin
          if (tcnt == T_FULL) begin
            tcnt <= '0;
            if (rxs) begin
              // Byte is dropped only when no slot is freed by a pop in this same cycle
              overrun <= fifo_full && !rd_en;
              state   <= IDLE;
            end else begin
              ferr  <= 1'b1;
              state <= BREAK;
            end
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        BREAK: begin
          // Hold here while the line stays low so a break reports a single framing error
          tcnt <= '0;
          if (rxs) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          tcnt  <= '0;
        end
      endcase
    end
  end

  uart_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .wr_en       (fifo_wr),
    .wdata       (shreg),
    .rd_en       (rd_en),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .full        (fifo_full),
    .count       (count)
  );

endmodule

// File: tb/tb_uart_rx_with_buf.sv
// tb/tb_uart_rx_with_buf.sv - self-checking bench for uart_rx_with_buf
module tb_uart_rx_with_buf;

  localparam int H  = 4;
  localparam int DL = 2;

  logic          clk   = 1'b0;
  logic          rstn  = 1'b0;
  logic          rxd   = 1'b1;
  logic          rd_en = 1'b0;
  logic [7:0]    rdata;
  logic          rdata_valid;
  logic [DL:0]   count;
  logic          ferr;
  logic          overrun;

  int errors = 0;
  int checks = 0;
  int ferr_hi = 0;
  int ovr_hi = 0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       pop;
    logic [7:0] head;
    int         cnt;
    int         ferrs;
  } vec_t;

  vec_t vecs [6];

  uart_rx_with_buf #(
    .CLK_PER_HALF_BIT (H),
    .DEPTH_LOG2       (DL)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .rxd         (rxd),
    .rd_en       (rd_en),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .count       (count),
    .ferr        (ferr),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // Count cycles each status pulse is high
  always @(negedge clk) begin
    if (ferr === 1'b1) ferr_hi++;
    if (overrun === 1'b1) ovr_hi++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_bit();
    idle(2 * H);
  endtask

  // Drives one frame; rxd is left at the stop level
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    wait_bit();
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_bit();
    end
    rxd = stop;
    wait_bit();
  endtask

  task automatic pop();
    rd_en = 1'b1;
    idle(1);
    rd_en = 1'b0;
  endtask

  task automatic reset_dut();
    rstn = 1'b0;
    rxd  = 1'b1;
    idle(3);
    rstn = 1'b1;
    idle(2);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " rdata"},   32'(rdata),       32'h00);
    chk({tag, " valid"},   32'(rdata_valid), 32'h0);
    chk({tag, " count"},   32'(count),       32'h0);
    chk({tag, " ferr"},    32'(ferr),        32'h0);
    chk({tag, " overrun"}, 32'(overrun),     32'h0);
  endtask

  initial begin
    int f0;
    int o0;
    logic [7:0] exp_b;

    vecs[0] = '{8'h00, 1'b1, 1'b0, 8'h00, 1, 0};
    vecs[1] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1, 0};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 8'hFF, 1, 1};
    vecs[3] = '{8'h81, 1'b1, 1'b1, 8'h81, 1, 1};
    vecs[4] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 1, 1};
    vecs[5] = '{8'hA5, 1'b0, 1'b1, 8'h00, 0, 2};

    rstn = 1'b0;
    idle(2);
    chk_reset_outputs("reset");
    rstn = 1'b1;
    idle(2);

    // Table-driven frames
    f0 = ferr_hi;
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].data, vecs[i].stop);
      rxd = 1'b1;
      idle(4);
      if (vecs[i].pop) pop();
      chk($sformatf("vec%0d head", i),  32'(rdata),       32'(vecs[i].head));
      chk($sformatf("vec%0d count", i), 32'(count),       32'(vecs[i].cnt));
      chk($sformatf("vec%0d valid", i), 32'(rdata_valid), 32'(vecs[i].cnt != 0));
      chk($sformatf("vec%0d ferr", i),  32'(ferr_hi - f0), 32'(vecs[i].ferrs));
    end

    // Single frame latency: stop sample at 79 cycles after rxd falls
    reset_dut();
    fork
      send_frame(8'hA5, 1'b1);
      begin
        repeat (78) @(posedge clk);
        @(negedge clk);
        chk("t1 valid before", 32'(rdata_valid), 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("t1 valid after", 32'(rdata_valid), 32'h1);
        chk("t1 rdata", 32'(rdata), 32'hA5);
        chk("t1 count", 32'(count), 32'h1);
      end
    join
    pop();
    chk("t1 pop valid", 32'(rdata_valid), 32'h0);
    chk("t1 pop rdata", 32'(rdata), 32'h00);

    // Five frames into a depth-4 FIFO
    o0 = ovr_hi;
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1);
    idle(4);
    chk("t2 count", 32'(count), 32'h4);
    chk("t2 overrun", 32'(ovr_hi - o0), 32'h1);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("t2 pop%0d", k), 32'(rdata), 32'(k));
      pop();
    end
    chk("t2 empty", 32'(count), 32'h0);

    // Full FIFO with a pop in the write cycle
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    send_frame(8'h44, 1'b1);
    o0 = ovr_hi;
    fork
      send_frame(8'h77, 1'b1);
      begin
        repeat (78) @(posedge clk);
        #1;
        rd_en = 1'b1;
        idle(1);
        rd_en = 1'b0;
      end
    join
    idle(4);
    chk("t3 count", 32'(count), 32'h4);
    chk("t3 overrun", 32'(ovr_hi - o0), 32'h0);
    for (int k = 0; k < 4; k++) begin
      exp_b = (k == 3) ? 8'h77 : 8'(8'h22 + 8'(k) * 8'h11);
      chk($sformatf("t3 pop%0d", k), 32'(rdata), 32'(exp_b));
      pop();
    end

    // Framing error followed by a held-low line
    f0 = ferr_hi;
    send_frame(8'h3C, 1'b0);
    idle(200);
    rxd = 1'b1;
    idle(10);
    send_frame(8'h5A, 1'b1);
    idle(4);
    chk("t4 ferr", 32'(ferr_hi - f0), 32'h1);
    chk("t4 count", 32'(count), 32'h1);
    chk("t4 head", 32'(rdata), 32'h5A);
    pop();

    // One-cycle glitch while idle
    f0 = ferr_hi;
    rxd = 1'b0;
    idle(1);
    rxd = 1'b1;
    idle(40);
    chk("t5 count", 32'(count), 32'h0);
    chk("t5 ferr", 32'(ferr_hi - f0), 32'h0);
    send_frame(8'h96, 1'b1);
    idle(4);
    chk("t5 next head", 32'(rdata), 32'h96);
    pop();

    // Reset after data bit 3
    f0 = ferr_hi;
    rxd = 1'b0;
    wait_bit();
    for (int i = 0; i < 4; i++) begin
      rxd = 1'b0;
      wait_bit();
    end
    rstn = 1'b0;
    rxd  = 1'b1;
    idle(1);
    chk_reset_outputs("t6 in reset");
    idle(2);
    rstn = 1'b1;
    idle(100);
    chk("t6 count", 32'(count), 32'h0);
    chk("t6 ferr", 32'(ferr_hi - f0), 32'h0);
    send_frame(8'hC3, 1'b1);
    idle(4);
    chk("t6 next count", 32'(count), 32'h1);
    chk("t6 next head", 32'(rdata), 32'hC3);
    pop();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
